fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: issues imem requests under FIFO credit and
// in-flight limits, pairs in-order responses with their PCs, and squashes on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        fifo_write_en,
    output logic [63:0] fifo_write_data,
    input  logic        fifo_pop,
    output logic        fifo_flush
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned NW = $clog2(MAX_INFLIGHT + 1);
    localparam int          FD = int'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(MAX_INFLIGHT - 1);

    logic [31:0]             pc_q;
    logic [CW-1:0]           credit_q;
    logic [CW-1:0]           credit_d;
    logic [NW-1:0]           count_q;
    logic [NW-1:0]           remain;
    logic [PW-1:0]           head_q;
    logic [PW-1:0]           tail_q;
    logic [31:0]             q_pc [MAX_INFLIGHT];
    logic [MAX_INFLIGHT-1:0] q_stale;
    logic                    issue;
    logic                    resp;
    logic                    accept;
    logic                    discard;
    int                      credit_sum;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign imem_req_valid = reset_n && fetch_en && !redirect_valid &&
                            (credit_q != '0) && (count_q < NW'(MAX_INFLIGHT));
    assign imem_req_addr  = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are strays (e.g. after reset) and are dropped.
    assign resp    = imem_resp_valid && (count_q != '0);
    assign accept  = resp && !q_stale[head_q] && !redirect_valid;
    assign discard = resp && !accept;
    assign remain  = count_q - NW'(resp);

    assign fifo_write_en   = accept;
    assign fifo_write_data = {q_pc[head_q], imem_resp_data};
    assign fifo_flush      = reset_n && redirect_valid;

    // A redirect flushes the FIFO, so only the surviving in-flight slots stay reserved.
    always_comb begin
        credit_sum = int'(credit_q) - int'(issue) + int'(discard) +
                     int'(fifo_pop && !redirect_valid);
        if (redirect_valid) credit_sum = FD - int'(remain);
        if (credit_sum > FD) credit_sum = FD;
        if (credit_sum < 0)  credit_sum = 0;
        credit_d = CW'(credit_sum);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            credit_q <= CW'(FIFO_DEPTH);
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            q_stale  <= '0;
            for (int unsigned i = 0; i < MAX_INFLIGHT; i++) q_pc[i] <= '0;
        end else begin
            credit_q <= credit_d;
            if (issue) begin
                q_pc[tail_q]    <= pc_q;
                q_stale[tail_q] <= 1'b0;
                tail_q          <= ptr_inc(tail_q);
                pc_q            <= pc_q + 32'd4;
            end
            if (resp) head_q <= ptr_inc(head_q);
            if (issue && !resp)      count_q <= count_q + NW'(1);
            else if (!issue && resp) count_q <= count_q - NW'(1);
            if (redirect_valid) begin
                pc_q    <= {redirect_pc[31:2], 2'b00};
                q_stale <= '1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a queue-based reference model, an
// in-order memory responder and a downstream FIFO occupancy model.
module tb_fetch_stage;
    localparam int          FD   = 8;
    localparam int          MAXI = 4;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        fifo_write_en;
    logic [63:0] fifo_write_data;
    logic        fifo_pop = 1'b0;
    logic        fifo_flush;

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(FD), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .fifo_write_en(fifo_write_en),
        .fifo_write_data(fifo_write_data), .fifo_pop(fifo_pop), .fifo_flush(fifo_flush)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; } ent_t;
    typedef struct { int due; logic [31:0] data; } mem_t;

    ent_t        inflight[$];
    mem_t        mem_q[$];
    logic [31:0] pc;
    int          credit;
    int          fifo_cnt;
    int          cyc;
    int          issues;
    int          checks = 0;
    int          errors = 0;

    int unsigned k_fe, k_rdy, k_pop, k_resp, k_redir, k_lat_min, k_lat_max;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit exp_valid, resp_eff, exp_we, issue;
        @(negedge clk);
        fetch_en        = (k_fe != 0);
        imem_req_ready  = ($urandom_range(99) < k_rdy);
        redirect_valid  = force_redir || ($urandom_range(999) < k_redir);
        redirect_pc     = force_redir ? force_pc : $urandom();
        fifo_pop        = (fifo_cnt > 0) && ($urandom_range(99) < k_pop);
        imem_resp_valid = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < k_resp);
        imem_resp_data  = imem_resp_valid ? mem_q[0].data : $urandom();
        #1;
        exp_valid = fetch_en && !redirect_valid && credit > 0 && inflight.size() < MAXI;
        resp_eff  = imem_resp_valid && inflight.size() > 0;
        exp_we    = resp_eff && !inflight[0].stale && !redirect_valid;
        chk("req_valid", 64'(imem_req_valid), 64'(exp_valid));
        chk("req_addr", 64'(imem_req_addr), 64'(pc));
        chk("flush", 64'(fifo_flush), 64'(redirect_valid));
        chk("write_en", 64'(fifo_write_en), 64'(exp_we));
        if (exp_we) chk("write_data", fifo_write_data, {inflight[0].pc, imem_resp_data});
        if (imem_req_valid && imem_req_ready) issues++;
        issue = exp_valid && imem_req_ready;
        @(posedge clk);
        cyc++;
        if (imem_resp_valid) void'(mem_q.pop_front());
        if (resp_eff) begin
            void'(inflight.pop_front());
            if (!exp_we) credit++;
        end
        if (fifo_pop && !redirect_valid) credit++;
        if (issue) begin
            inflight.push_back('{pc: pc, stale: 1'b0});
            mem_q.push_back('{due: cyc + int'($urandom_range(k_lat_max, k_lat_min)) - 1, data: $urandom()});
            credit--;
            pc += 32'd4;
        end
        if (redirect_valid) begin
            pc = redirect_pc & ~32'h3;
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            credit   = FD - inflight.size();
            fifo_cnt = 0;
        end else begin
            fifo_cnt = fifo_cnt + int'(exp_we) - int'(fifo_pop);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; fetch_en = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; imem_resp_valid = 1'b1; fifo_pop = 1'b0;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_write_en", 64'(fifo_write_en), 64'd0);
        chk("rst_flush", 64'(fifo_flush), 64'd0);
        chk("rst_addr", 64'(imem_req_addr), 64'(RPC));
        imem_resp_valid = 1'b0;
        pc = RPC; credit = FD; fifo_cnt = 0;
        inflight.delete();
        repeat (2) begin @(posedge clk); cyc++; end
        #2 reset_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        k_fe = 0; k_resp = 100; k_redir = 0;
        while (mem_q.size() > 0 && n < 64) begin step(); n++; end
        if (mem_q.size() > 0) chk("drain_timeout", 64'(mem_q.size()), 64'd0);
    endtask

    task automatic set_knobs(input int unsigned fe, rdy, pop, lat);
        k_fe = fe; k_rdy = rdy; k_pop = pop; k_resp = 100; k_redir = 0;
        k_lat_min = lat; k_lat_max = lat;
    endtask

    task automatic fill_to(input int target);
        int n = 0;
        while (inflight.size() != target && n < 40) begin step(); n++; end
        if (inflight.size() != target) chk("fill_timeout", 64'(inflight.size()), 64'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; issues = 0; pc = RPC; credit = FD; fifo_cnt = 0;
        set_knobs(0, 0, 0, 1);
        do_reset();

        // Credit cap: no pops means exactly FIFO_DEPTH issues, one pop frees one more.
        set_knobs(1, 100, 0, 1);
        issues = 0;
        repeat (16) step();
        chk("issue_cap", 64'(issues), 64'd8);
        k_pop = 100; step(); k_pop = 0;
        repeat (6) step();
        chk("issue_after_pop", 64'(issues), 64'd9);

        // Redirect with three in flight, then confirm the full credit returns.
        do_reset(); drain();
        set_knobs(1, 100, 100, 3);
        fill_to(3);
        force_redir = 1'b1; force_pc = 32'h0000_1003;
        step();
        force_redir = 1'b0;
        #1 chk("redir_addr", 64'(imem_req_addr), 64'h1000);
        drain();
        set_knobs(1, 100, 0, 3);
        issues = 0;
        repeat (20) step();
        chk("credit_restore", 64'(issues), 64'd8);

        // Reset with two in flight; stray responses must be ignored afterwards.
        do_reset(); drain();
        set_knobs(1, 100, 100, 3);
        fill_to(2);
        do_reset(); drain();

        for (int r = 0; r < 40; r++) begin
            k_fe      = ($urandom_range(9) != 0) ? 1 : 0;
            k_rdy     = $urandom_range(100, 30);
            k_pop     = $urandom_range(100, 0);
            k_resp    = $urandom_range(100, 50);
            k_redir   = $urandom_range(50, 0);
            k_lat_min = $urandom_range(3, 1);
            k_lat_max = k_lat_min + $urandom_range(4, 0);
            repeat (80) step();
            if (r % 10 == 9) begin do_reset(); drain(); end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
